// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - writer, scanner and RAM pins of the frame-buffer port arbiter
//
// Signals (directions as seen by the arbiter, modport slave):
//   wr_valid/wr_ready/wr_addr/wr_data : posted host pixel writes
//   rd_req/rd_addr/rd_gnt             : scanner read request and combinational grant
//   rd_valid/rd_data                  : scanner read return
//   ram_addr/ram_wdata/ram_we/ram_q   : single-port frame-buffer RAM
// The master modport is the environment side (writer, scanner and RAM).
interface fb_port_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_q;

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_q,
      output wr_ready, rd_gnt, rd_valid, rd_data, ram_addr, ram_wdata, ram_we
   );

   modport master (
      output wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_q,
      input  wr_ready, rd_gnt, rd_valid, rd_data, ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - shares one 8K x 16 frame-buffer RAM port between host writer and scan reader
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   bus       : fb_port_arbiter_if.slave (writer, scanner and RAM pins)
//   stall_cnt : saturating count of cycles the writer was back-pressured (FB_ARB_STATS_EN only)
//   max_fill  : peak write-FIFO occupancy since reset (FB_ARB_STATS_EN only)
// Optional statistics are built only when the macro FB_ARB_STATS_EN is defined.
module fb_port_arbiter #(
   parameter int ADDR_W        = 13,
   parameter int DATA_W        = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_RD_STREAK = 8,
   parameter int RAM_RD_LAT    = 1
) (
   input  logic                               clk,
   input  logic                               reset,
`ifdef FB_ARB_STATS_EN
   output logic [15:0]                        stall_cnt,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    max_fill,
`endif
   fb_port_arbiter_if.slave                   bus
);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int STRK_W = $clog2(MAX_RD_STREAK + 1);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

   logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [STRK_W-1:0]     streak_q, streak_d;
   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
   logic [RAM_RD_LAT-1:0] vld_q, vld_d;
   logic [DATA_W-1:0]     rd_data_q;
   logic                  fifo_empty, fifo_full;
   logic                  push, pop;
   logic                  rd_gnt, wr_gnt;

   assign fifo_empty   = (count_q == '0);
   assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
   // Full blocks the writer even if a pop happens this cycle, keeping wr_ready a pure flop decode.
   assign bus.wr_ready = ~reset & ~fifo_full;
   assign push         = bus.wr_valid & bus.wr_ready;
   assign pop          = wr_gnt;

   // Arbitration / next-state. The state records the grant type of this cycle;
   // it directly becomes the registered RAM write enable and read-pipe input.
   always_comb begin
      state_d     = S_IDLE;
      rd_gnt      = 1'b0;
      wr_gnt      = 1'b0;
      streak_d    = streak_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if (!reset) begin
         if (bus.rd_req && (fifo_empty || streak_q < STRK_W'(MAX_RD_STREAK))) begin
            rd_gnt     = 1'b1;
            state_d    = S_RD;
            ram_addr_d = bus.rd_addr;
         end else if (!fifo_empty) begin
            // Reached only with rd_req low or the read streak exhausted.
            wr_gnt      = 1'b1;
            state_d     = S_WR;
            ram_addr_d  = fifo_addr_q[rd_ptr_q];
            ram_wdata_d = fifo_data_q[rd_ptr_q];
         end
      end
      // The streak only matters while a write is waiting.
      if (wr_gnt || fifo_empty) begin
         streak_d = '0;
      end else if (rd_gnt) begin
         streak_d = streak_q + STRK_W'(1);
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Read-valid shift pipe: stage 0 loads in the cycle after the grant.
   always_comb begin
      vld_d = RAM_RD_LAT'({vld_q, (state_q == S_RD)});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         streak_q    <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         vld_q       <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         count_q     <= count_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         vld_q       <= vld_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (vld_d[RAM_RD_LAT-1]) begin
            rd_data_q <= bus.ram_q;
         end
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
         fifo_data_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.rd_gnt    = rd_gnt;
   assign bus.ram_we    = (state_q == S_WR);
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.rd_valid  = vld_q[RAM_RD_LAT-1];
   assign bus.rd_data   = rd_data_q;

`ifdef FB_ARB_STATS_EN
   logic [15:0]      stall_cnt_q;
   logic [CNT_W-1:0] max_fill_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         max_fill_q  <= '0;
      end else begin
         if (bus.wr_valid && !bus.wr_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (count_d > max_fill_q) begin
            max_fill_q <= count_d;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign max_fill  = max_fill_q;
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - randomized self-checking bench for fb_port_arbiter
module tb_fb_port_arbiter;
   localparam int DEPTH = 4;
   localparam int MAXS  = 8;
   localparam int LAT   = 1;

   typedef struct {
      logic [12:0] a;
      logic [15:0] d;
   } wr_ent_t;

   typedef struct {
      int          due;
      logic [15:0] d;
   } rd_ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fb_port_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();

`ifdef FB_ARB_STATS_EN
   logic [15:0] stall_cnt;
   logic [2:0]  max_fill;
`endif

   fb_port_arbiter #(
      .ADDR_W(13), .DATA_W(16), .FIFO_DEPTH(DEPTH),
      .MAX_RD_STREAK(MAXS), .RAM_RD_LAT(LAT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef FB_ARB_STATS_EN
      .stall_cnt(stall_cnt),
      .max_fill (max_fill),
`endif
      .bus      (bus)
   );

   // Bench RAM: combinational read of the registered address (one-cycle latency).
   logic [15:0] ram_m [8192];
   assign bus.ram_q = ram_m[bus.ram_addr];

   // Reference model state
   logic [15:0] mem_m [8192];
   wr_ent_t     fq[$];
   rd_ent_t     pend[$];
   int          streak;
   logic        m_we;
   logic [12:0] m_addr;
   logic [15:0] m_wdata;
   int          cyc;
   bit          init_done;
   bit          last_rg;
   bit          last_push;
   int          stall_m;
   int          max_m;

   int          n_chk;
   int          n_err;

   logic        rq_cur;
   logic [12:0] ra_cur;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, advance the model.
   task automatic cycle(input logic rst, input logic wv, input logic [12:0] wa,
                        input logic [15:0] wd, input logic rq, input logic [12:0] ra);
      bit          empty, exp_rdy, rg, wg, exp_v, we_s;
      logic [12:0] a_s;
      logic [15:0] d_s;
      wr_ent_t     e;
      reset        = rst;
      bus.wr_valid = wv;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      bus.rd_req   = rq;
      bus.rd_addr  = ra;
      @(negedge clk);
      empty   = (fq.size() == 0);
      exp_rdy = !rst && (fq.size() < DEPTH);
      rg      = !rst && rq && (empty || streak < MAXS);
      wg      = !rst && !empty && (!rq || streak == MAXS);
      chk("wr_ready", 32'(bus.wr_ready), 32'(exp_rdy));
      chk("rd_gnt", 32'(bus.rd_gnt), 32'(rg));
      if (init_done) begin
         chk("ram_we", 32'(bus.ram_we), 32'(m_we));
         chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
         chk("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
         exp_v = (pend.size() > 0) && (pend[0].due == cyc);
         chk("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
         if (exp_v) begin
            chk("rd_data", 32'(bus.rd_data), 32'(pend[0].d));
            void'(pend.pop_front());
         end
`ifdef FB_ARB_STATS_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
         chk("max_fill", 32'(max_fill), 32'(max_m));
`endif
      end
      we_s = bus.ram_we;
      a_s  = bus.ram_addr;
      d_s  = bus.ram_wdata;
      last_push = 0;
      if (rst) begin
         fq.delete();
         pend.delete();
         streak  = 0;
         m_we    = 1'b0;
         m_addr  = '0;
         m_wdata = '0;
         stall_m = 0;
         max_m   = 0;
      end else begin
         m_we = 1'b0;
         if (wg) begin
            e = fq.pop_front();
            mem_m[e.a] = e.d;
            m_we    = 1'b1;
            m_addr  = e.a;
            m_wdata = e.d;
            streak  = 0;
         end
         if (rg) begin
            pend.push_back('{cyc + 1 + LAT, mem_m[ra]});
            m_addr = ra;
            if (!empty) streak++;
         end
         if (empty) streak = 0;
         if (wv && !exp_rdy && stall_m < 65535) stall_m++;
         if (wv && exp_rdy) begin
            fq.push_back('{wa, wd});
            last_push = 1;
         end
         if (fq.size() > max_m) max_m = fq.size();
      end
      last_rg = rg;
      @(posedge clk);
      if (init_done && we_s) ram_m[a_s] = d_s;
      if (rst) init_done = 1;
      cyc++;
      #1;
   endtask

   task automatic rand_phase(input int n, input int wpct, input int rpct, input int rstpm);
      for (int i = 0; i < n; i++) begin
         if (!rq_cur || last_rg) begin
            rq_cur = ($urandom_range(99) < rpct);
            ra_cur = 13'($urandom_range(31));
         end
         cycle($urandom_range(999) < rstpm, $urandom_range(99) < wpct,
               13'($urandom_range(31)), 16'($urandom), rq_cur, ra_cur);
      end
   endtask

   initial begin
      int pushes;
      int guard;
      logic [12:0] ra;
      for (int i = 0; i < 8192; i++) begin
         ram_m[i] = 16'(i);
         mem_m[i] = 16'(i);
      end
      n_chk = 0; n_err = 0; cyc = 0; init_done = 0; streak = 0;
      stall_m = 0; max_m = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      rq_cur = 0; ra_cur = '0; last_rg = 0; last_push = 0;

      // Reset, then a single posted write with no reads.
      cycle(1, 0, '0, '0, 0, '0);
      cycle(0, 1, 13'h0005, 16'h1234, 0, '0);
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, '0, 0, '0);

      // Eight back-to-back reads of 0x0100..0x0107.
      ra = 13'h0100;
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, '0, '0, (ra < 13'h0108), ra);
         if (last_rg) ra++;
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, 0, '0);

      // Streak limit: reads held continuously, one word posted.
      ra = 13'h0200;
      cycle(0, 1, 13'h0300, 16'hBEEF, 1, ra);
      for (int i = 0; i < 14; i++) begin
         if (last_rg) ra++;
         cycle(0, 0, '0, '0, 1, ra);
      end

      // Six back-to-back pushes against a held read request.
      pushes = 0;
      guard  = 0;
      while (pushes < 6 && guard < 100) begin
         if (last_rg) ra++;
         cycle(0, 1, 13'(13'h0400 + pushes), 16'(16'hA000 + pushes), 1, ra);
         if (last_push) pushes++;
         guard++;
      end
      chk("push_bound", 32'(pushes), 32'd6);
      for (int i = 0; i < 60; i++) begin
         if (last_rg) ra++;
         cycle(0, 0, '0, '0, (i < 40), ra);
      end

      // Reset with three words queued and a read in flight.
      cycle(0, 1, 13'h0010, 16'h1111, 1, 13'h0020);
      cycle(0, 1, 13'h0011, 16'h2222, 1, 13'h0021);
      cycle(0, 1, 13'h0012, 16'h3333, 1, 13'h0022);
      cycle(1, 0, '0, '0, 0, '0);
      for (int i = 0; i < 5; i++) cycle(0, 0, '0, '0, 0, '0);

      // Writer held against a full FIFO while reads hog the port.
      for (int i = 0; i < 20; i++) cycle(0, 1, 13'(i), 16'(i * 7), 1, 13'h0050);

      // Randomized traffic, including occasional resets.
      rand_phase(1500, 50, 60, 5);
      rand_phase(1000, 90, 90, 2);
      rand_phase(1000, 20, 30, 10);
      rq_cur = 0;
      for (int i = 0; i < 20; i++) cycle(0, 0, '0, '0, 0, '0);
      chk("pend_drained", 32'(pend.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
